// File: rtl/imem_loader.sv
// Loads a framed byte-stream program image into the IRAM as 32-bit little-endian words.
// Latency: 4th byte of a word accepted on edge t -> imem_wren high in cycle t+1; checksum byte -> done/error on edge t.
// Backpressure: byte_ready is low outside COUNT/DATA/CHECK (notably for the single WRITE cycle); the sender holds its byte.
//
// Ports:
//   clock, clear (async active-low)   - clocking and reset
//   start                             - begin-load pulse, honoured only in IDLE/DONE/ERR
//   byte_in/byte_valid/byte_ready     - stream byte input, transfer = valid & ready
//   imem_addr/imem_din/imem_wren      - registered IRAM write port
//   core_clear                        - active-low core clear, low while loading and after a failed load
//   busy/done/error                   - mutually exclusive status flags decoded from the state
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              imem_wren,
    output logic              core_clear,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // FSM encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    // IRAM capacity in words, widened so it compares cleanly against a 9-bit word count.
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    // Word counts run 1..256, so the count and word index need 9 bits regardless of ADDR_W.
    logic [2:0]        state_q,     state_d;
    logic [8:0]        n_q,         n_d;
    logic [8:0]        widx_q,      widx_d;
    logic [1:0]        bidx_q,      bidx_d;
    logic [7:0]        acc_q,       acc_d;
    logic [23:0]       word_q,      word_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_din_q,  imem_din_d;
    logic              imem_wren_q, imem_wren_d;

    logic       xfer;
    logic [8:0] n_byte;
    logic       too_big;
    logic [8:0] widx_inc;

    // byte_ready depends only on registered state, so it never combinationally follows byte_valid.
    assign byte_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
    assign busy       = (state_q == S_COUNT) || (state_q == S_DATA) ||
                        (state_q == S_WRITE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    // The core runs only from a clean idle or a verified image; a failed load keeps it held.
    assign core_clear = (state_q == S_IDLE) || (state_q == S_DONE);

    assign imem_addr  = imem_addr_q;
    assign imem_din   = imem_din_q;
    assign imem_wren  = imem_wren_q;

    assign xfer     = byte_valid & byte_ready;
    // A count byte of zero encodes the maximum image of 256 words.
    assign n_byte   = (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
    assign too_big  = ({23'd0, n_byte} > DEPTH);
    assign widx_inc = widx_q + 9'd1;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        acc_d       = acc_q;
        word_d      = word_q;
        imem_addr_d = imem_addr_q;
        imem_din_d  = imem_din_q;
        // The write strobe is a one-cycle pulse raised only on entry to WRITE.
        imem_wren_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_COUNT;
                    widx_d  = 9'd0;
                    bidx_d  = 2'd0;
                    acc_d   = 8'd0;
                end
            end

            S_COUNT: begin
                if (xfer) begin
                    n_d     = n_byte;
                    // An oversized image is rejected before any IRAM write.
                    state_d = too_big ? S_ERR : S_DATA;
                end
            end

            S_DATA: begin
                if (xfer) begin
                    acc_d  = acc_q ^ byte_in;
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0:    word_d[7:0]   = byte_in;
                        2'd1:    word_d[15:8]  = byte_in;
                        2'd2:    word_d[23:16] = byte_in;
                        default: begin
                            // The top byte goes straight into the write register
                            // so the word is presented in the very next cycle.
                            state_d     = S_WRITE;
                            imem_wren_d = 1'b1;
                            imem_addr_d = ADDR_W'(widx_q);
                            imem_din_d  = {byte_in, word_q};
                        end
                    endcase
                end
            end

            S_WRITE: begin
                widx_d  = widx_inc;
                state_d = (widx_inc == n_q) ? S_CHECK : S_DATA;
            end

            S_CHECK: begin
                if (xfer) begin
                    state_d = (byte_in == acc_q) ? S_DONE : S_ERR;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= S_IDLE;
            n_q         <= 9'd0;
            widx_q      <= 9'd0;
            bidx_q      <= 2'd0;
            acc_q       <= 8'd0;
            word_q      <= 24'd0;
            imem_addr_q <= '0;
            imem_din_q  <= 32'd0;
            imem_wren_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            acc_q       <= acc_d;
            word_q      <= word_d;
            imem_addr_q <= imem_addr_d;
            imem_din_q  <= imem_din_d;
            imem_wren_q <= imem_wren_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected IRAM writes, a monitor pops and compares.
// Latency: checks status on the falling edge right after the checksum byte transfers.
// Backpressure: the byte driver holds byte_valid until byte_ready is seen, with a bounded wait.
module tb_imem_loader;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  imem_addr;
    logic [31:0] imem_din;
    logic        imem_wren;
    logic        core_clear;
    logic        busy;
    logic        done;
    logic        error;

    // Second instance with a 128-word IRAM for the oversize-count case.
    logic        start7;
    logic [7:0]  byte_in7;
    logic        byte_valid7;
    logic        byte_ready7;
    logic [6:0]  imem_addr7;
    logic [31:0] imem_din7;
    logic        imem_wren7;
    logic        core_clear7;
    logic        busy7;
    logic        done7;
    logic        error7;

    imem_loader #(.ADDR_W(8)) u_dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_addr  (imem_addr),
        .imem_din   (imem_din),
        .imem_wren  (imem_wren),
        .core_clear (core_clear),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    imem_loader #(.ADDR_W(7)) u_dut7 (
        .clock      (clock),
        .clear      (clear),
        .start      (start7),
        .byte_in    (byte_in7),
        .byte_valid (byte_valid7),
        .byte_ready (byte_ready7),
        .imem_addr  (imem_addr7),
        .imem_din   (imem_din7),
        .imem_wren  (imem_wren7),
        .core_clear (core_clear7),
        .busy       (busy7),
        .done       (done7),
        .error      (error7)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          wr7_cnt  = 0;
    logic        wren_prev = 1'b0;
    logic [39:0] exp_q[$];
    logic [31:0] frame_w[$];
    logic [7:0]  t1b [0:9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every IRAM write is checked against the head of the expected queue.
    always @(negedge clock) begin
        if (clear) begin
            chk("status_exclusive", {63'd0, (busy & done) | (busy & error) | (done & error)}, 64'd0);
            if (imem_wren) begin
                logic [39:0] e;
                wr_cnt++;
                chk("ready_in_write", {63'd0, byte_ready}, 64'd0);
                chk("wren_back_to_back", {63'd0, wren_prev}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_din);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {56'd0, imem_addr}, {56'd0, e[39:32]});
                    chk("wr_data", {32'd0, imem_din}, {32'd0, e[31:0]});
                end
            end
            if (imem_wren7) wr7_cnt++;
            wren_prev = imem_wren;
        end else begin
            wren_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        if (gap) begin
            repeat ($urandom_range(0, 3)) begin
                byte_in = 8'($urandom);
                @(posedge clock);
                #1;
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        @(negedge clock);
        while (!byte_ready && waited < 100) begin
            waited++;
            @(negedge clock);
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: byte_ready stayed 0 for byte 0x%0h, expected 1", b);
        end
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Sends count, the words in frame_w (LS byte first), then the checksum byte.
    task automatic send_frame(input logic [7:0] cnt, input logic [7:0] cks, input bit gap);
        for (int i = 0; i < frame_w.size(); i++) exp_q.push_back({8'(i), frame_w[i]});
        send_byte(cnt, gap);
        for (int i = 0; i < frame_w.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                w = frame_w[i];
                send_byte(w[8*k +: 8], gap);
            end
        end
        send_byte(cks, gap);
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err, input logic e_cc);
        @(negedge clock);
        chk({tag, "_done"},       {63'd0, done},       {63'd0, e_done});
        chk({tag, "_error"},      {63'd0, error},      {63'd0, e_err});
        chk({tag, "_core_clear"}, {63'd0, core_clear}, {63'd0, e_cc});
        chk({tag, "_busy"},       {63'd0, busy},       64'd0);
        chk({tag, "_pending"},    64'(exp_q.size()),   64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int waited;

        t1b = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        clear = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        start7 = 1'b0; byte_in7 = 8'h00; byte_valid7 = 1'b0;

        // Reset state
        #12;
        chk("rst_wren",       {63'd0, imem_wren},  64'd0);
        chk("rst_addr",       {56'd0, imem_addr},  64'd0);
        chk("rst_din",        {32'd0, imem_din},   64'd0);
        chk("rst_ready",      {63'd0, byte_ready}, 64'd0);
        chk("rst_core_clear", {63'd0, core_clear}, 64'd1);
        chk("rst_busy",       {63'd0, busy},       64'd0);
        chk("rst_done",       {63'd0, done},       64'd0);
        chk("rst_error",      {63'd0, error},      64'd0);
        @(posedge clock);
        #1;
        clear = 1'b1;

        // Test 1: good load of two words
        frame_w = '{32'h00500093, 32'h00100113};
        w0 = wr_cnt;
        pulse_start();
        chk("t1_busy_in_count",       {63'd0, busy},       64'd1);
        chk("t1_core_held_in_count",  {63'd0, core_clear}, 64'd0);
        send_frame(8'h02, 8'hC1, 1'b0);
        check_status("t1", 1'b1, 1'b0, 1'b1);
        chk("t1_write_count", 64'(wr_cnt - w0), 64'd2);

        // Test 2: bad checksum keeps the written words and the core held
        w0 = wr_cnt;
        pulse_start();
        send_frame(8'h02, 8'hC0, 1'b0);
        check_status("t2_bad", 1'b0, 1'b1, 1'b0);
        chk("t2_write_count", 64'(wr_cnt - w0), 64'd2);
        pulse_start();
        send_frame(8'h02, 8'hC1, 1'b0);
        check_status("t2_good", 1'b1, 1'b0, 1'b1);

        // Test 3: random bubbles on the byte stream
        w0 = wr_cnt;
        pulse_start();
        send_frame(8'h02, 8'hC1, 1'b1);
        check_status("t3", 1'b1, 1'b0, 1'b1);
        chk("t3_write_count", 64'(wr_cnt - w0), 64'd2);

        // Test 4: full depth, 256 words of incrementing bytes; every byte value appears
        // four times so the XOR checksum is zero.
        frame_w.delete();
        for (int i = 0; i < 256; i++)
            frame_w.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        w0 = wr_cnt;
        pulse_start();
        send_frame(8'h00, 8'h00, 1'b0);
        check_status("t4", 1'b1, 1'b0, 1'b1);
        chk("t4_write_count", 64'(wr_cnt - w0), 64'd256);

        // Test 4b: 256 words do not fit a 128-word IRAM
        start7 = 1'b1;
        @(posedge clock);
        #1;
        start7      = 1'b0;
        byte_in7    = 8'h00;
        byte_valid7 = 1'b1;
        waited      = 0;
        @(negedge clock);
        while (!byte_ready7 && waited < 100) begin
            waited++;
            @(negedge clock);
        end
        chk("t4b_ready_in_count", {63'd0, byte_ready7}, 64'd1);
        @(posedge clock);
        #1;
        byte_valid7 = 1'b0;
        @(negedge clock);
        chk("t4b_error",      {63'd0, error7},      64'd1);
        chk("t4b_busy",       {63'd0, busy7},       64'd0);
        chk("t4b_core_clear", {63'd0, core_clear7}, 64'd0);
        repeat (3) @(negedge clock);
        chk("t4b_no_writes",  64'(wr7_cnt),         64'd0);
        @(posedge clock);
        #1;

        // Test 5: asynchronous reset after five data bytes (first word already written)
        exp_q.push_back({8'h00, 32'h00500093});
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(t1b[i], 1'b0);
        #2;
        clear = 1'b0;
        #1;
        chk("t5_wren",       {63'd0, imem_wren},  64'd0);
        chk("t5_core_clear", {63'd0, core_clear}, 64'd1);
        chk("t5_busy",       {63'd0, busy},       64'd0);
        chk("t5_ready",      {63'd0, byte_ready}, 64'd0);
        chk("t5_din",        {32'd0, imem_din},   64'd0);
        chk("t5_pending",    64'(exp_q.size()),   64'd0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        frame_w = '{32'h00500093, 32'h00100113};
        pulse_start();
        send_frame(8'h02, 8'hC1, 1'b0);
        check_status("t5", 1'b1, 1'b0, 1'b1);

        // Test 6: start pulsed in DATA is ignored
        exp_q.push_back({8'h00, 32'h00500093});
        exp_q.push_back({8'h01, 32'h00100113});
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(t1b[i], 1'b0);
            if (i == 2) begin
                pulse_start();
                chk("t6_busy_after_start",  {63'd0, busy},       64'd1);
                chk("t6_ready_after_start", {63'd0, byte_ready}, 64'd1);
            end
        end
        check_status("t6", 1'b1, 1'b0, 1'b1);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
